// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle sequencer.
// Phase encoding is visible on phase_o, so the numbering is fixed.
package cpu_pkg;

    localparam int PHASE_W = 3;
    localparam int WAIT_W  = 8;

    typedef enum logic [PHASE_W-1:0] {
        RESET  = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } phase_t;

endpackage

// File: rtl/phase_wait_cnt.sv
// 8-bit up/down counter with load and terminal-match flag.
// Ports: clk, rst_n; load/load_val preset; en steps (up=1 inc, up=0 dec);
//        term_val compare target; cnt current value; term = (cnt == term_val).
module phase_wait_cnt
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              en,
    input  logic              up,
    input  logic [WAIT_W-1:0] term_val,
    output logic [WAIT_W-1:0] cnt,
    output logic              term
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= up ? cnt + WAIT_W'(1) : cnt - WAIT_W'(1);
        end
    end

    assign term = (cnt == term_val);

endmodule

// File: rtl/cpu_phase_ctrl.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB with clock enables.
// Ports: clk, rst_n; decoder mem_op_i/mem_wr_i/reg_wr_i; alu_complete,
//        mem_ack_i, halt_i; enables ir_en_o, alu_start_o, mem_req_o,
//        mem_we_o, reg_we_o, pc_en_o; phase_o, instret_o, fault_o.
module cpu_phase_ctrl
    import cpu_pkg::*;
#(
    parameter int FETCH_WAIT  = 2,
    parameter int ALU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_op_i,
    input  logic               mem_wr_i,
    input  logic               reg_wr_i,
    input  logic               alu_complete,
    input  logic               mem_ack_i,
    input  logic               halt_i,
    output logic               ir_en_o,
    output logic               alu_start_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               reg_we_o,
    output logic               pc_en_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic [CNT_W-1:0]   instret_o,
    output logic               fault_o
);

    localparam logic [WAIT_W-1:0] FW_LAST = WAIT_W'(FETCH_WAIT - 1);
    localparam logic [WAIT_W-1:0] TMO     = WAIT_W'(ALU_TIMEOUT);

    phase_t            state;
    phase_t            next;
    logic [WAIT_W-1:0] cnt;
    logic              cnt_term;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_up;
    logic [WAIT_W-1:0] cnt_load_val;
    logic [WAIT_W-1:0] cnt_term_val;
    logic              ir_last;

    // One counter serves both phases: FETCH counts down to 0,
    // EXEC counts up from 1 so cnt equals the current EXEC cycle.
    always_comb begin
        cnt_up       = (next == EXEC);
        cnt_load     = (next != state) && (next == FETCH || next == EXEC);
        cnt_load_val = (next == EXEC) ? WAIT_W'(1) : FW_LAST;
        cnt_en       = (next == state) && (state == FETCH || state == EXEC);
        cnt_term_val = (state == EXEC) ? TMO : '0;
    end

    phase_wait_cnt u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .up       (cnt_up),
        .term_val (cnt_term_val),
        .cnt      (cnt),
        .term     (cnt_term)
    );

    always_comb begin
        next = state;
        unique case (state)
            RESET:  next = FETCH;
            FETCH:  if (cnt_term) next = DECODE;
            DECODE: next = EXEC;
            EXEC: begin
                if (alu_complete) next = mem_op_i ? MEM : WB;
                else if (cnt_term) next = FAULT;
            end
            MEM:    if (mem_ack_i) next = WB;
            WB:     next = halt_i ? HALT : FETCH;
            HALT:   if (!halt_i) next = FETCH;
            FAULT:  next = FAULT;
        endcase
    end

    // Next cycle is the final FETCH cycle when the counter will sit at 0.
    always_comb begin
        ir_last = 1'b0;
        if (next == FETCH) begin
            ir_last = (state != FETCH) ? (FW_LAST == '0)
                                       : (cnt == WAIT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RESET;
            ir_en_o     <= 1'b0;
            alu_start_o <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            reg_we_o    <= 1'b0;
            pc_en_o     <= 1'b0;
            fault_o     <= 1'b0;
            instret_o   <= '0;
        end else begin
            state       <= next;
            ir_en_o     <= ir_last;
            alu_start_o <= (next == EXEC) && (state != EXEC);
            mem_req_o   <= (next == MEM);
            mem_we_o    <= (next == MEM) && mem_wr_i;
            reg_we_o    <= (next == WB) && reg_wr_i;
            pc_en_o     <= (next == WB);
            fault_o     <= (next == FAULT);
            if (next == WB) instret_o <= instret_o + CNT_W'(1);
        end
    end

    assign phase_o = state;

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Self-checking bench for cpu_phase_ctrl: per-instruction cycle plans
// built from phase lengths, replayed and compared every cycle.
module tb_cpu_phase_ctrl;
    import cpu_pkg::*;

    localparam int FW  = 2;
    localparam int TMO = 64;

    typedef struct {
        logic [2:0]  ph;
        logic        ir, st, mr, mw, rw, pc, flt;
        logic [31:0] ret;
        logic        mo, mwi, rwi, cmp, ack, hlt;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_op_i = 0, mem_wr_i = 0, reg_wr_i = 0;
    logic        alu_complete = 0, mem_ack_i = 0, halt_i = 0;
    logic        ir_en_o, alu_start_o, mem_req_o, mem_we_o;
    logic        reg_we_o, pc_en_o, fault_o;
    logic [2:0]  phase_o;
    logic [31:0] instret_o;
    logic        s_ir, s_st, s_mr, s_mw, s_rw, s_pc, s_flt;
    logic [2:0]  s_phase;
    logic [1:0]  s_instret;

    rec_t        q[$];
    rec_t        plan[$];
    rec_t        cr;
    logic [31:0] m_ret = 0;
    int          errs = 0;
    int          checks = 0;
    int          pc_seen = 0;
    int          run = 0;
    int          last_mem_run = 0;
    int          lit_idx = 0;
    logic [2:0]  prev = 3'd0;
    int          lit_ph[5] = '{1, 1, 2, 3, 5};
    logic [9:0]  ev, av, sv;

    always #5 clk = ~clk;

    cpu_phase_ctrl #(.FETCH_WAIT(FW), .ALU_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_op_i(mem_op_i), .mem_wr_i(mem_wr_i), .reg_wr_i(reg_wr_i),
        .alu_complete(alu_complete), .mem_ack_i(mem_ack_i), .halt_i(halt_i),
        .ir_en_o(ir_en_o), .alu_start_o(alu_start_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .reg_we_o(reg_we_o), .pc_en_o(pc_en_o),
        .phase_o(phase_o), .instret_o(instret_o), .fault_o(fault_o)
    );

    cpu_phase_ctrl #(.FETCH_WAIT(FW), .ALU_TIMEOUT(TMO), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .mem_op_i(mem_op_i), .mem_wr_i(mem_wr_i), .reg_wr_i(reg_wr_i),
        .alu_complete(alu_complete), .mem_ack_i(mem_ack_i), .halt_i(halt_i),
        .ir_en_o(s_ir), .alu_start_o(s_st), .mem_req_o(s_mr),
        .mem_we_o(s_mw), .reg_we_o(s_rw), .pc_en_o(s_pc),
        .phase_o(s_phase), .instret_o(s_instret), .fault_o(s_flt)
    );

    // Per-cycle compare against the replayed plan.
    always @(negedge clk) begin
        if (!rst_n) begin
            pc_seen = 0;
            run = 0;
            prev = 3'd0;
        end else if (q.size() != 0) begin
            cr = q.pop_front();
            ev = {cr.ph, cr.ir, cr.st, cr.mr, cr.mw, cr.rw, cr.pc, cr.flt};
            av = {phase_o, ir_en_o, alu_start_o, mem_req_o, mem_we_o,
                  reg_we_o, pc_en_o, fault_o};
            sv = {s_phase, s_ir, s_st, s_mr, s_mw, s_rw, s_pc, s_flt};
            checks++;
            if (av !== ev || instret_o !== cr.ret) begin
                errs++;
                $display("FAIL cycle t=%0t act=%b/%0d exp=%b/%0d",
                         $time, av, instret_o, ev, cr.ret);
            end
            checks++;
            if (sv !== ev || s_instret !== cr.ret[1:0]) begin
                errs++;
                $display("FAIL cnt2_cycle t=%0t act=%b/%0d exp=%b/%0d",
                         $time, sv, s_instret, ev, cr.ret[1:0]);
            end
            if (pc_en_o) pc_seen++;
            checks++;
            if (!$onehot0({ir_en_o, alu_start_o, mem_req_o, pc_en_o}) ||
                (reg_we_o && !pc_en_o) || instret_o !== 32'(pc_seen)) begin
                errs++;
                $display("FAIL onehot_instret t=%0t en=%b instret=%0d pulses=%0d",
                         $time, av[6:0], instret_o, pc_seen);
            end
            if (lit_idx < 5) begin
                checks++;
                if (32'(phase_o) != 32'(lit_ph[lit_idx])) begin
                    errs++;
                    $display("FAIL lit_phase%0d act=%0d exp=%0d",
                             lit_idx, phase_o, lit_ph[lit_idx]);
                end
                if (lit_idx == 4) begin
                    checks++;
                    if (!(pc_en_o && reg_we_o) || instret_o != 32'd1) begin
                        errs++;
                        $display("FAIL lit_wb act=%b%b/%0d exp=11/1",
                                 pc_en_o, reg_we_o, instret_o);
                    end
                end
                lit_idx++;
            end
            if (phase_o == prev) begin
                run++;
            end else begin
                if (prev == 3'(MEM)) last_mem_run = run;
                if (prev == 3'(EXEC) && phase_o == 3'(FAULT)) begin
                    checks++;
                    if (run != TMO) begin
                        errs++;
                        $display("FAIL exec_timeout act=%0d exp=%0d", run, TMO);
                    end
                end
                run = 1;
            end
            prev = phase_o;
        end
    end

    function automatic rec_t blank(logic [2:0] ph);
        rec_t r;
        r.ph = ph;
        r.ir = 0; r.st = 0; r.mr = 0; r.mw = 0;
        r.rw = 0; r.pc = 0; r.flt = 0;
        r.ret = m_ret;
        r.mo = 1'($urandom_range(0, 1));
        r.mwi = 1'($urandom_range(0, 1));
        r.rwi = 1'($urandom_range(0, 1));
        r.cmp = 1'($urandom_range(0, 1));
        r.ack = 1'($urandom_range(0, 1));
        r.hlt = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // k = EXEC cycle of completion (0: never), m = MEM cycles, h = HALT cycles
    task automatic gen(bit mo, bit mw, bit rw, int k, int m, int h);
        rec_t r;
        int ne;
        ne = (k == 0) ? TMO : k;
        for (int i = 0; i < FW; i++) begin
            r = blank(3'(FETCH)); r.ir = (i == FW - 1); plan.push_back(r);
        end
        r = blank(3'(DECODE));
        r.mo = mo; r.mwi = mw; r.rwi = rw; plan.push_back(r);
        for (int j = 1; j <= ne; j++) begin
            r = blank(3'(EXEC));
            r.mo = mo; r.mwi = mw; r.rwi = rw;
            r.st = (j == 1); r.cmp = (k != 0) && (j == k);
            plan.push_back(r);
        end
        if (k == 0) begin
            for (int i = 0; i < 5; i++) begin
                r = blank(3'(FAULT)); r.flt = 1; plan.push_back(r);
            end
            return;
        end
        if (mo) begin
            for (int j = 1; j <= m; j++) begin
                r = blank(3'(MEM));
                r.mo = mo; r.mwi = mw; r.rwi = rw;
                r.mr = 1; r.mw = mw; r.ack = (j == m);
                plan.push_back(r);
            end
        end
        m_ret++;
        r = blank(3'(WB));
        r.mo = mo; r.mwi = mw; r.rwi = rw;
        r.rw = rw; r.pc = 1; r.hlt = (h > 0);
        plan.push_back(r);
        for (int j = 1; j <= h; j++) begin
            r = blank(3'(HALT)); r.hlt = (j < h); plan.push_back(r);
        end
    endtask

    task automatic play(int n);
        int lim;
        lim = (n < 0) ? plan.size() : n;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #1;
            mem_op_i = plan[i].mo;
            mem_wr_i = plan[i].mwi;
            reg_wr_i = plan[i].rwi;
            alu_complete = plan[i].cmp;
            mem_ack_i = plan[i].ack;
            halt_i = plan[i].hlt;
            q.push_back(plan[i]);
        end
        plan.delete();
    endtask

    task automatic chk_zero(string nm);
        checks++;
        if ({phase_o, ir_en_o, alu_start_o, mem_req_o, mem_we_o, reg_we_o,
             pc_en_o, fault_o} !== 10'd0 || instret_o !== 32'd0) begin
            errs++;
            $display("FAIL %s act=%0d/%b%b%b%b%b%b%b/%0d exp=0/0000000/0",
                     nm, phase_o, ir_en_o, alu_start_o, mem_req_o, mem_we_o,
                     reg_we_o, pc_en_o, fault_o, instret_o);
        end
    endtask

    task automatic do_reset(string nm);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk_zero(nm);
        m_ret = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset_state");
        rst_n = 1;

        gen(0, 0, 1, 1, 0, 0);
        play(-1);

        gen(1, 0, 1, 3, 4, 0);
        gen(1, 1, 0, 3, 4, 0);
        play(-1);
        checks++;
        if (instret_o !== 32'd3) begin
            errs++;
            $display("FAIL lit_instret3 act=%0d exp=3", instret_o);
        end

        gen(0, 0, 1, 2, 1, 3);
        play(-1);
        checks++;
        if (last_mem_run != 4) begin
            errs++;
            $display("FAIL lit_mem_run act=%0d exp=4", last_mem_run);
        end

        for (int n = 0; n < 1500; n++) begin
            gen(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(1, 6),
                $urandom_range(1, 5),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            play(-1);
        end

        gen(0, 0, 1, 0, 0, 0);
        play(-1);
        do_reset("reset_from_fault");

        gen(1, 1, 1, 2, 6, 0);
        play(FW + 1 + 2 + 2);
        do_reset("reset_in_mem");

        gen(1, 0, 1, 1, 1, 0);
        gen(0, 0, 0, 2, 1, 0);
        play(-1);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
